// File: rtl/arm_prog_loader.sv
// rtl/arm_prog_loader.sv - boot-time byte-stream program loader for arm_memory/arm_core
module arm_prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_write_en,
  output logic        core_rst,
  input  logic        core_halted,
  output logic        running,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic [15:0] n_q, n_d;
  logic [15:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic [31:0] full_word;

  // Outputs are gated by rst so nothing leaks out while reset is being held.
  assign in_ready     = rst && (state_q == S_HDR || state_q == S_DATA);
  assign mem_write_en = rst && (state_q == S_WRITE);
  assign core_rst     = !rst || !(state_q == S_RUN || state_q == S_DONE);
  assign running      = rst && (state_q == S_RUN);
  assign done         = rst && (state_q == S_DONE);
  assign err          = rst && (state_q == S_ERR);
  assign mem_addr     = addr_q;
  assign mem_data_in  = wdata_q;
  assign words_loaded = words_q;

  assign accept    = in_valid && in_ready;
  assign full_word = {in_data, asm_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    n_d     = n_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_HDR, S_DATA: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (state_q == S_HDR) begin
              if (full_word == 32'd0 || full_word > MAX_W) begin
                state_d = S_ERR;
              end else begin
                n_d     = full_word[15:0];
                state_d = S_DATA;
              end
            end else begin
              wdata_d = full_word;
              addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
              state_d = S_WRITE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0:    asm_d[7:0]   = in_data;
              2'd1:    asm_d[15:8]  = in_data;
              default: asm_d[23:16] = in_data;
            endcase
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        state_d = (words_q + 16'd1 == n_q) ? S_RUN : S_DATA;
      end
      S_RUN: begin
        if (core_halted) state_d = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_HDR;
      idx_q   <= 2'd0;
      asm_q   <= 24'd0;
      n_q     <= 16'd0;
      words_q <= 16'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      n_q     <= n_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_arm_prog_loader.sv
// tb/tb_arm_prog_loader.sv - self-checking bench for arm_prog_loader
module tb_arm_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        core_halted = 1'b0;

  logic        in_ready_a, wen_a, core_rst_a, running_a, done_a, err_a;
  logic [31:0] addr_a, data_a;
  logic [15:0] words_a;
  logic        in_ready_b, wen_b, core_rst_b, running_b, done_b, err_b;
  logic [31:0] addr_b, data_b;
  logic [15:0] words_b;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] obs_a[$];
  logic [63:0] obs_b[$];

  typedef struct {
    logic [31:0] n_hdr;
    int          mode;
    logic [31:0] w0;
    bit          pat;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  arm_prog_loader dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .mem_addr(addr_a), .mem_data_in(data_a), .mem_write_en(wen_a), .core_rst(core_rst_a),
    .core_halted(core_halted), .running(running_a), .done(done_a), .err(err_a),
    .words_loaded(words_a)
  );

  arm_prog_loader #(.BASE_ADDR(32'h0000_0100)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .mem_addr(addr_b), .mem_data_in(data_b), .mem_write_en(wen_b), .core_rst(core_rst_b),
    .core_halted(core_halted), .running(running_b), .done(done_b), .err(err_b),
    .words_loaded(words_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wen_a) begin
      obs_a.push_back({addr_a, data_a});
      chk("in_ready_during_write", {31'd0, in_ready_a}, 32'd0);
    end
    if (wen_b) obs_b.push_back({addr_b, data_b});
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst_a}, 32'd1);
    chk("rst_wen", {31'd0, wen_a}, 32'd0);
    chk("rst_flags", {29'd0, running_a, done_a, err_a}, 32'd0);
    chk("rst_words", {16'd0, words_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    chk("post_rst_addr", addr_a, 32'd0);
    chk("post_rst_data", data_a, 32'd0);
    chk("post_rst_core_rst", {31'd0, core_rst_a}, 32'd1);
    @(posedge clk); #1;
    obs_a.delete();
    obs_b.delete();
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random valid
  task automatic send_bytes(input logic [7:0] bq[$], input int mode);
    int idx = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit acc;
    int budget = 20 * bq.size() + 100;
    while (idx < bq.size() && cyc < budget) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      in_data = bq[idx];
      @(negedge clk);
      acc = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < bq.size()) chk("send_timeout", 32'(idx), 32'(bq.size()));
  endtask

  task automatic offer_extra();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      chk("extra_in_ready_a", {31'd0, in_ready_a}, 32'd0);
      chk("extra_in_ready_b", {31'd0, in_ready_b}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic compare_writes(input logic [31:0] words[$]);
    chk("write_count_a", 32'(obs_a.size()), 32'(words.size()));
    chk("write_count_b", 32'(obs_b.size()), 32'(words.size()));
    for (int i = 0; i < words.size(); i++) begin
      if (i < obs_a.size()) begin
        chk("write_addr_a", obs_a[i][63:32], 32'(4 * i));
        chk("write_data_a", obs_a[i][31:0], words[i]);
      end
      if (i < obs_b.size()) begin
        chk("write_addr_b", obs_b[i][63:32], 32'h100 + 32'(4 * i));
        chk("write_data_b", obs_b[i][31:0], words[i]);
      end
    end
  endtask

  task automatic run_case(input logic [31:0] n_hdr, input int mode, input logic [31:0] w0,
                          input bit pat, input bit exp_err, input bit skip_reset);
    logic [31:0] words[$];
    logic [7:0]  bq[$];
    logic [31:0] w;
    int nw;
    nw = exp_err ? 0 : int'(n_hdr);
    if (!skip_reset) do_reset();
    for (int i = 0; i < nw; i++)
      words.push_back(pat ? w0 * 32'(i + 1) : (i == 0 ? w0 : $urandom));
    w = n_hdr;
    for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
    end
    send_bytes(bq, mode);
    @(negedge clk);
    if (exp_err) begin
      chk("err_flag", {31'd0, err_a}, 32'd1);
      chk("err_in_ready", {31'd0, in_ready_a}, 32'd0);
      chk("err_core_rst", {31'd0, core_rst_a}, 32'd1);
      chk("err_words", {16'd0, words_a}, 32'd0);
      @(posedge clk); #1;
      offer_extra();
      chk("err_still", {31'd0, err_a}, 32'd1);
    end else begin
      chk("last_write_wen", {31'd0, wen_a}, 32'd1);
      chk("last_write_core_rst", {31'd0, core_rst_a}, 32'd1);
      chk("last_write_words", {16'd0, words_a}, 32'(nw - 1));
      @(negedge clk);
      chk("release_core_rst", {31'd0, core_rst_a}, 32'd0);
      chk("release_running", {31'd0, running_a}, 32'd1);
      chk("release_words", {16'd0, words_a}, 32'(nw));
      chk("release_wen", {31'd0, wen_a}, 32'd0);
      @(posedge clk); #1;
      offer_extra();
      chk("final_words_b", {16'd0, words_b}, 32'(nw));
    end
    compare_writes(words);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pq[$];
    logic [31:0] hw[$];
    int cnt;

    vecs[0] = '{32'd1,          0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[1] = '{32'd3,          1, 32'h1111_1111, 1'b1, 1'b0};
    vecs[2] = '{32'd0,          0, 32'd0,         1'b0, 1'b1};
    vecs[3] = '{32'd1025,       0, 32'd0,         1'b0, 1'b1};
    vecs[4] = '{32'h8000_0001,  2, 32'd0,         1'b0, 1'b1};
    vecs[5] = '{32'd2,          2, 32'h0BAD_F00D, 1'b0, 1'b0};
    vecs[6] = '{32'd1024,       0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[7] = '{32'd5,          2, 32'hFFFF_FFFF, 1'b0, 1'b0};

    foreach (vecs[i])
      run_case(vecs[i].n_hdr, vecs[i].mode, vecs[i].w0, vecs[i].pat, vecs[i].exp_err, 1'b0);

    for (int r = 0; r < 5; r++)
      run_case(32'($urandom_range(1, 8)), 2, $urandom, 1'b0, 1'b0, 1'b0);

    // Halt handling: halted held high during the load must be ignored.
    do_reset();
    core_halted = 1'b1;
    pq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_bytes(pq, 0);
    core_halted = 1'b0;
    chk("halt_ignored_during_load", {30'd0, done_a, running_a}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) core_halted = 1'b1;
      @(negedge clk);
      if (running_a) cnt++;
    end
    chk("running_cycles", 32'(cnt), 32'd3);
    chk("done_flag", {31'd0, done_a}, 32'd1);
    chk("done_running", {31'd0, running_a}, 32'd0);
    chk("done_core_rst", {31'd0, core_rst_a}, 32'd0);
    @(posedge clk); #1;
    core_halted = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_sticky", {31'd0, done_a}, 32'd1);
    hw = '{32'h0403_0201, 32'h0807_0605};
    compare_writes(hw);
    @(posedge clk); #1;

    // Reset mid-word: stale bytes must not merge into the restreamed word.
    do_reset();
    pq = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h99, 8'h88};
    send_bytes(pq, 0);
    chk("pre_reset_words", {16'd0, words_a}, 32'd1);
    do_reset();
    run_case(32'd1, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
